// File: rtl/oszto_pkg.sv
// oszto_pkg
// Shared definitions for the restoring divider: FSM state encoding and the
// width helper for the CALC bit counter.
package oszto_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    CALC = 3'd2,
    FIX  = 3'd3,
    KESZ = 3'd4
  } state_t;

  // Counter must hold BITS-1; never narrower than one bit.
  function automatic int cnt_width(input int bits);
    return (bits < 2) ? 1 : $clog2(bits);
  endfunction

endpackage

// File: rtl/oszto_lepes.sv
// oszto_lepes
// One combinational restoring-division step: shift {rem, quo} left by one,
// trial-subtract the divisor, keep or restore, and shift in the quotient bit.
// Ports:
//   i_rem  [BITS-1:0]  partial remainder before the step (always < i_dvsr)
//   i_quo  [BITS-1:0]  quotient shift register before the step
//   i_dvsr [BITS-1:0]  divisor magnitude (non-zero)
//   o_rem  [BITS-1:0]  partial remainder after the step
//   o_quo  [BITS-1:0]  quotient shift register after the step
module oszto_lepes #(
  parameter int BITS = 8
) (
  input  logic [BITS-1:0] i_rem,
  input  logic [BITS-1:0] i_quo,
  input  logic [BITS-1:0] i_dvsr,
  output logic [BITS-1:0] o_rem,
  output logic [BITS-1:0] o_quo
);

  logic [BITS:0] w_shift;
  logic [BITS:0] w_diff;
  logic          w_ok;

  assign w_shift = {i_rem, i_quo[BITS-1]};
  assign w_diff  = w_shift - {1'b0, i_dvsr};

  // If the shifted remainder overflowed into bit BITS it is certainly larger
  // than any BITS-bit divisor; otherwise the top bit of the difference is
  // its sign.
  assign w_ok = w_shift[BITS] | ~w_diff[BITS];

  // On restore the shifted value is below the divisor, so it fits BITS bits.
  assign o_rem = w_ok ? w_diff[BITS-1:0] : w_shift[BITS-1:0];
  assign o_quo = {i_quo[BITS-2:0], w_ok};

endmodule

// File: rtl/oszto_radix2.sv
// oszto_radix2
// Sequential restoring integer divider, one quotient bit per clock, fixed
// latency. Optional two's-complement mode truncating toward zero.
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous active-low reset
//   start     request a division (sampled in IDLE or KESZ)
//   a, b      dividend / divisor, captured on the accepting edge
//   hanyados  quotient (registered)
//   maradek   remainder (registered)
//   hiba      divide-by-zero flag, valid while ready
//   ovf       signed overflow flag (most-negative / -1), valid while ready
//   ready     result valid (KESZ)
//   busy      operation in progress (PREP, CALC, FIX)
//
// state | meaning
// IDLE  | waiting for start after reset
// PREP  | take magnitudes, record signs, load shift registers
// CALC  | BITS shift/subtract iterations
// FIX   | apply signs, flag overflow, load result registers
// KESZ  | result valid; start here begins the next division
module oszto_radix2
  import oszto_pkg::*;
#(
  parameter int BITS   = 8,
  parameter int SIGNED = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  output logic [BITS-1:0] hanyados,
  output logic [BITS-1:0] maradek,
  output logic            hiba,
  output logic            ovf,
  output logic            ready,
  output logic            busy
);

  localparam int              CW       = cnt_width(BITS);
  localparam logic [CW-1:0]   CNT_LAST = CW'(BITS - 1);
  localparam logic [BITS-1:0] MOST_NEG = {1'b1, {(BITS-1){1'b0}}};
  localparam bit              SGN      = (SIGNED != 0);

  state_t          r_state;
  state_t          w_state_nxt;

  logic [BITS-1:0] r_a;
  logic [BITS-1:0] r_b;
  logic [BITS-1:0] r_rem;
  logic [BITS-1:0] r_q;
  logic [BITS-1:0] r_dvsr;
  logic [CW-1:0]   r_cnt;
  logic            r_neg_q;
  logic            r_neg_r;
  logic [BITS-1:0] r_hanyados;
  logic [BITS-1:0] r_maradek;
  logic            r_hiba;
  logic            r_ovf;

  logic            w_b_zero;
  logic [BITS-1:0] w_mag_a;
  logic [BITS-1:0] w_mag_b;
  logic [BITS-1:0] w_step_rem;
  logic [BITS-1:0] w_step_quo;
  logic            w_ovf;

  assign w_b_zero = (b == '0);

  // In signed mode the most negative value negates to itself, which read as
  // unsigned is exactly 2^(BITS-1), the magnitude we want.
  assign w_mag_a = (SGN && r_a[BITS-1]) ? (~r_a + 1'b1) : r_a;
  assign w_mag_b = (SGN && r_b[BITS-1]) ? (~r_b + 1'b1) : r_b;

  assign w_ovf = SGN && (r_a == MOST_NEG) && (r_b == '1);

  oszto_lepes #(
    .BITS (BITS)
  ) u_lepes (
    .i_rem  (r_rem),
    .i_quo  (r_q),
    .i_dvsr (r_dvsr),
    .o_rem  (w_step_rem),
    .o_quo  (w_step_quo)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, KESZ: begin
        if (start) begin
          w_state_nxt = w_b_zero ? KESZ : PREP;
        end
      end
      PREP: w_state_nxt = CALC;
      CALC: begin
        if (r_cnt == '0) begin
          w_state_nxt = FIX;
        end
      end
      FIX:     w_state_nxt = KESZ;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a        <= '0;
      r_b        <= '0;
      r_rem      <= '0;
      r_q        <= '0;
      r_dvsr     <= '0;
      r_cnt      <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_hanyados <= '0;
      r_maradek  <= '0;
      r_hiba     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      case (r_state)
        IDLE, KESZ: begin
          if (start) begin
            if (w_b_zero) begin
              r_hanyados <= '1;
              r_maradek  <= a;
              r_hiba     <= 1'b1;
              r_ovf      <= 1'b0;
            end else begin
              r_a    <= a;
              r_b    <= b;
              r_hiba <= 1'b0;
              r_ovf  <= 1'b0;
            end
          end
        end
        PREP: begin
          r_neg_r <= SGN && r_a[BITS-1];
          r_neg_q <= SGN && (r_a[BITS-1] ^ r_b[BITS-1]);
          r_dvsr  <= w_mag_b;
          r_q     <= w_mag_a;
          r_rem   <= '0;
          r_cnt   <= CNT_LAST;
        end
        CALC: begin
          r_rem <= w_step_rem;
          r_q   <= w_step_quo;
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        FIX: begin
          // Overflow case needs no special handling: |MIN|/1 = 2^(BITS-1)
          // with a positive quotient sign already reads as MIN, remainder 0.
          r_hanyados <= r_neg_q ? (~r_q + 1'b1) : r_q;
          r_maradek  <= r_neg_r ? (~r_rem + 1'b1) : r_rem;
          r_ovf      <= w_ovf;
        end
        default: begin
        end
      endcase
    end
  end

  assign hanyados = r_hanyados;
  assign maradek  = r_maradek;
  assign hiba     = r_hiba;
  assign ovf      = r_ovf;
  assign ready    = (r_state == KESZ);
  assign busy     = (r_state == PREP) || (r_state == CALC) || (r_state == FIX);

endmodule

// File: tb/tb_oszto_radix2.sv
// tb_oszto_radix2
// Drives an unsigned and a signed instance in lockstep with the same inputs
// and compares both against an integer-arithmetic reference model.
module tb_oszto_radix2;

  localparam int BITS = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic [BITS-1:0] a = '0;
  logic [BITS-1:0] b = '0;

  logic [BITS-1:0] q_u, r_u, q_s, r_s;
  logic            h_u, o_u, rdy_u, bsy_u;
  logic            h_s, o_s, rdy_s, bsy_s;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  oszto_radix2 #(.BITS(BITS), .SIGNED(0)) u_dut_u (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .hanyados(q_u), .maradek(r_u), .hiba(h_u), .ovf(o_u),
    .ready(rdy_u), .busy(bsy_u)
  );

  oszto_radix2 #(.BITS(BITS), .SIGNED(1)) u_dut_s (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .hanyados(q_s), .maradek(r_s), .hiba(h_s), .ovf(o_s),
    .ready(rdy_s), .busy(bsy_s)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic void ref_div(input logic [7:0] da, input logic [7:0] db, input bit sgn,
                                  output logic [7:0] q, output logic [7:0] r,
                                  output logic hb, output logic ov);
    int sa, sb;
    hb = 1'b0;
    ov = 1'b0;
    if (db == 8'h00) begin
      q  = 8'hFF;
      r  = da;
      hb = 1'b1;
    end else if (sgn) begin
      sa = int'($signed(da));
      sb = int'($signed(db));
      q  = 8'(sa / sb);
      r  = 8'(sa % sb);
      ov = (sa == -128) && (sb == -1);
    end else begin
      q = 8'(int'(da) / int'(db));
      r = 8'(int'(da) % int'(db));
    end
  endfunction

  task automatic check_res(input string tag, input logic [7:0] ia, input logic [7:0] ib);
    logic [7:0] q, r;
    logic       hb, ov;
    ref_div(ia, ib, 1'b0, q, r, hb, ov);
    chk({tag, "/q_u"}, q_u, q);
    chk({tag, "/r_u"}, r_u, r);
    chk({tag, "/hiba_u"}, h_u, hb);
    chk({tag, "/ovf_u"}, o_u, ov);
    ref_div(ia, ib, 1'b1, q, r, hb, ov);
    chk({tag, "/q_s"}, q_s, q);
    chk({tag, "/r_s"}, r_s, r);
    chk({tag, "/hiba_s"}, h_s, hb);
    chk({tag, "/ovf_s"}, o_s, ov);
  endtask

  // Called just after a clock edge; returns just after the edge where ready rose.
  task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input bit scramble,
                        input string tag);
    int n;
    a = ia;
    b = ib;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (ib == 8'h00) begin
      chk({tag, "/rdy_z"}, {rdy_u, rdy_s}, 2'b11);
      chk({tag, "/bsy_z"}, {bsy_u, bsy_s}, 2'b00);
    end else begin
      chk({tag, "/rdy_acc"}, {rdy_u, rdy_s}, 2'b00);
      chk({tag, "/bsy_acc"}, {bsy_u, bsy_s}, 2'b11);
      n = 0;
      while (!(rdy_u || rdy_s) && n < 40) begin
        if (scramble) begin
          a = 8'($urandom);
          b = 8'($urandom);
        end
        @(posedge clk);
        #1;
        n++;
      end
      chk({tag, "/lat"}, n, BITS + 2);
      chk({tag, "/rdy"}, {rdy_u, rdy_s, bsy_u, bsy_s}, 4'b1100);
    end
    check_res(tag, ia, ib);
  endtask

  initial begin
    logic [7:0] ra, rb;
    #1;
    chk("rst/out_u", {q_u, r_u, h_u, o_u, rdy_u, bsy_u}, '0);
    chk("rst/out_s", {q_s, r_s, h_s, o_s, rdy_s, bsy_s}, '0);
    #20;
    rst = 1'b1;
    @(posedge clk);
    #1;

    run_op(8'd200, 8'd7, 1'b0, "d200_7");
    run_op(8'hF9, 8'h02, 1'b0, "dm7_2");
    run_op(8'h07, 8'hFE, 1'b0, "d7_m2");
    run_op(8'h80, 8'hFF, 1'b0, "dmin_m1");
    run_op(8'h55, 8'h00, 1'b0, "dz55");

    // KESZ holds its result while start stays low.
    repeat (3) @(posedge clk);
    #1;
    chk("hold/rdy", {rdy_u, rdy_s}, 2'b11);
    check_res("hold", 8'h55, 8'h00);

    run_op(8'd100, 8'd3, 1'b1, "scr100_3");
    // Back-to-back: start issued straight from KESZ.
    run_op(8'd9, 8'd9, 1'b0, "b2b9_9");

    // Asynchronous reset in the 4th CALC cycle.
    a = 8'd200;
    b = 8'd13;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("arst/out_u", {q_u, r_u, h_u, o_u, rdy_u, bsy_u}, '0);
    chk("arst/out_s", {q_s, r_s, h_s, o_s, rdy_s, bsy_s}, '0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("arst/idle", {rdy_u, bsy_u, rdy_s, bsy_s}, 4'b0000);
    run_op(8'd15, 8'd4, 1'b0, "post15_4");

    for (int i = 0; i < 60; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      case ($urandom_range(0, 9))
        0:       rb = 8'h00;
        1:       begin ra = 8'h80; rb = 8'hFF; end
        2:       rb = 8'hFF;
        3:       rb = 8'h01;
        default: ;
      endcase
      run_op(ra, rb, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
